// File: rtl/zil_pkg.sv
// Shared definitions for the apartment door-bell responder and the panel-side monitor.
// Holds the state encoding, the idle call code and the debug durum constants.
package zil_pkg;

   typedef enum logic [1:0] {
      BOSTA   = 2'd0,
      CALIYOR = 2'd1,
      ACIK    = 2'd2,
      ALARM   = 2'd3
   } durum_t;

   localparam logic [3:0] IDLE_KOD = 4'b0000;

   localparam logic [1:0] DURUM_BOSTA   = 2'd0;
   localparam logic [1:0] DURUM_CALIYOR = 2'd1;
   localparam logic [1:0] DURUM_ACIK    = 2'd2;
   localparam logic [1:0] DURUM_ALARM   = 2'd3;

endpackage

// File: rtl/kenar_algila.sv
// Rising-edge detector: remembers the previous level in a register and pulses
// for one cycle when the input goes from low to high.
module kenar_algila (
   input  logic clk,
   input  logic rst_n,
   input  logic giris,
   output logic darbe
);

   logic onceki_r;

   // Previous-level register, cleared by reset so a level held across reset rises again.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         onceki_r <= 1'b0;
      end else begin
         onceki_r <= giris;
      end
   end

   assign darbe = giris & ~onceki_r;

endmodule

// File: rtl/zil_cevaplayici.sv
// Apartment-side door-bell responder: detects calls for this flat, rings the chime,
// takes the resident's open/reject decision, counts missed calls and flags nuisance ringing.
module zil_cevaplayici
   import zil_pkg::*;
#(
   parameter logic [3:0] DAIRE_NO   = 4'd5,
   parameter int         CALMA_SURE = 8,
   parameter int         CEVAP_SURE = 32,
   parameter int         ACIK_SURE  = 4,
   parameter int         MAX_TEKRAR = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] cagri_kodu,
   input  logic       cevap_butonu,
   input  logic       red_butonu,
   input  logic       alarm_sustur,
   output logic       zil_cal,
   output logic       kapi_ac,
   output logic       alarm,
   output logic [3:0] cevapsiz_sayisi,
   output logic [1:0] durum
);

   localparam int TW = (CEVAP_SURE > 1) ? $clog2(CEVAP_SURE) : 1;
   localparam int KW = (MAX_TEKRAR > 0) ? $clog2(MAX_TEKRAR + 1) : 1;

   localparam logic [TW-1:0] TMR_CEVAP = TW'(CEVAP_SURE - 1);
   localparam logic [TW-1:0] TMR_ACIK  = TW'(ACIK_SURE - 1);
   localparam logic [TW-1:0] ZIL_ESIK  = TW'(CEVAP_SURE - CALMA_SURE);

   generate
      if ((ACIK_SURE > CEVAP_SURE) || (ACIK_SURE < 1)) begin : g_acik_hata
         $error("ACIK_SURE must be in 1..CEVAP_SURE");
      end
      if ((CALMA_SURE > CEVAP_SURE) || (DAIRE_NO == 4'd0)) begin : g_param_hata
         $error("CALMA_SURE must not exceed CEVAP_SURE and DAIRE_NO must be non-zero");
      end
   endgenerate

   durum_t        durum_r, durum_s;
   logic [TW-1:0] timer_r, timer_s;
   logic [KW-1:0] tekrar_r, tekrar_s;
   logic [3:0]    sayac_r, sayac_s;
   logic          zil_r, zil_s;
   logic          kapi_r, kapi_s;
   logic          alarm_r, alarm_s;
   logic          eslesme_s;
   logic          cagri_s;
   logic          tekrar_son_s;

   assign eslesme_s = (cagri_kodu == DAIRE_NO) && (cagri_kodu != IDLE_KOD);

   kenar_algila u_kenar (
      .clk   (clk),
      .rst_n (rst_n),
      .giris (eslesme_s),
      .darbe (cagri_s)
   );

   assign tekrar_son_s = ((int'(tekrar_r) + 1) == MAX_TEKRAR);

   // Next state, timer and counters; outputs are derived from the current state
   // and registered, so they lag the state register by one cycle.
   always_comb begin
      durum_s = durum_r;
      timer_s = timer_r;
      tekrar_s = tekrar_r;
      sayac_s = sayac_r;
      zil_s = (durum_r == CALIYOR) && (timer_r >= ZIL_ESIK);
      kapi_s = (durum_r == ACIK);
      alarm_s = (durum_r == ALARM);
      case (durum_r)
         BOSTA: begin
            if (cagri_s) begin
               durum_s = CALIYOR;
               timer_s = TMR_CEVAP;
               tekrar_s = {KW{1'b0}};
            end else begin
               durum_s = BOSTA;
            end
         end
         CALIYOR: begin
            if (red_butonu) begin
               durum_s = BOSTA;
            end else if (cevap_butonu) begin
               durum_s = ACIK;
               timer_s = TMR_ACIK;
            end else if (cagri_s) begin
               if (tekrar_son_s) begin
                  durum_s = ALARM;
               end else begin
                  tekrar_s = tekrar_r + KW'(1);
                  timer_s = TMR_CEVAP;
               end
            end else if (timer_r == {TW{1'b0}}) begin
               durum_s = BOSTA;
               if (sayac_r != 4'd15) begin
                  sayac_s = sayac_r + 4'd1;
               end else begin
                  sayac_s = sayac_r;
               end
            end else begin
               timer_s = timer_r - TW'(1);
            end
         end
         ACIK: begin
            if (timer_r == {TW{1'b0}}) begin
               durum_s = BOSTA;
            end else begin
               timer_s = timer_r - TW'(1);
            end
         end
         ALARM: begin
            if (alarm_sustur) begin
               durum_s = BOSTA;
               tekrar_s = {KW{1'b0}};
            end else begin
               durum_s = ALARM;
            end
         end
         default: begin
            durum_s = BOSTA;
         end
      endcase
   end

   // State, timer, counters and output registers; reset aborts any activity at once.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         durum_r  <= BOSTA;
         timer_r  <= {TW{1'b0}};
         tekrar_r <= {KW{1'b0}};
         sayac_r  <= 4'd0;
         zil_r    <= 1'b0;
         kapi_r   <= 1'b0;
         alarm_r  <= 1'b0;
      end else begin
         durum_r  <= durum_s;
         timer_r  <= timer_s;
         tekrar_r <= tekrar_s;
         sayac_r  <= sayac_s;
         zil_r    <= zil_s;
         kapi_r   <= kapi_s;
         alarm_r  <= alarm_s;
      end
   end

   assign zil_cal         = zil_r;
   assign kapi_ac         = kapi_r;
   assign alarm           = alarm_r;
   assign cevapsiz_sayisi = sayac_r;
   assign durum           = durum_r;

endmodule
